// File: rtl/fp_pkg.sv
// Shared binary32 constants and FSM state type for the floating-point datapath.
// The floating-point adder is expected to import this package as well.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int FP_BIAS = 127;

    localparam logic [EXP_W-1:0] FP_EXP_MAX = 8'hFF;
    localparam logic [31:0]      FP_QNAN    = 32'h7F800001;

    typedef enum logic [2:0] {
        IDLE,
        CHECKS,
        MULT,
        NORM,
        ROUND,
        FINISHED
    } state_t;

endpackage

// File: rtl/multiplier_fp_if.sv
// start/ready/busy handshake bundle shared by the multiplier and the adder.
interface multiplier_fp_if;

    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready;
    logic        busy;
    logic [31:0] Y;

    modport master (output start, A, B, input ready, busy, Y);
    modport slave  (input start, A, B, output ready, busy, Y);

endinterface

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier; denormals are reported as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output logic        sign,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign sign    = value[31];
    assign exp_f   = value[FRAC_W +: EXP_W];
    assign frac_f  = value[FRAC_W-1:0];

    assign is_nan  = (exp_f == FP_EXP_MAX) && (frac_f != '0);
    assign is_inf  = (exp_f == FP_EXP_MAX) && (frac_f == '0);
    assign is_zero = (exp_f == '0);

endmodule

// File: rtl/multiplier_fp.sv
// Multi-cycle binary32 multiplier: 24-step shift-add mantissa product,
// single guard bit rounding (half away from zero), denormals flushed to zero.
module multiplier_fp
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    multiplier_fp_if.slave  bus
);

    state_t state, next_state;

    logic [31:0]        a_reg, b_reg;
    logic [23:0]        mcand, mplier;
    logic [47:0]        prod;
    logic [4:0]         count;
    logic signed [9:0]  exp_sum;
    logic [FRAC_W-1:0]  mant;
    logic               guard;
    logic [31:0]        y_reg;
    logic               ready_reg, busy_reg;

    logic sign_a, nan_a, inf_a, zero_a;
    logic sign_b, nan_b, inf_b, zero_b;

    logic               res_sign;
    logic               special;
    logic [31:0]        special_y;
    logic [FRAC_W:0]    rounded;
    logic signed [9:0]  exp_round;

    fp_classify u_cls_a (
        .value   (a_reg),
        .sign    (sign_a),
        .is_nan  (nan_a),
        .is_inf  (inf_a),
        .is_zero (zero_a)
    );

    fp_classify u_cls_b (
        .value   (b_reg),
        .sign    (sign_b),
        .is_nan  (nan_b),
        .is_inf  (inf_b),
        .is_zero (zero_b)
    );

    // Priority order matters: NaN beats Inf*0, which beats plain Inf, which beats zero.
    always_comb begin
        res_sign  = sign_a ^ sign_b;
        special   = 1'b1;
        special_y = FP_QNAN;
        if (nan_a || nan_b) begin
            special_y = FP_QNAN;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            special_y = FP_QNAN;
        end else if (inf_a || inf_b) begin
            special_y = {res_sign, FP_EXP_MAX, {FRAC_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            special_y = {res_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
        end else begin
            special   = 1'b0;
            special_y = '0;
        end
    end

    always_comb begin
        rounded   = {1'b0, mant} + {{FRAC_W{1'b0}}, guard};
        exp_round = rounded[FRAC_W] ? exp_sum + 10'sd1 : exp_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.start) next_state = CHECKS;
            CHECKS:   next_state = special ? FINISHED : MULT;
            MULT:     if (count == 5'd23) next_state = NORM;
            NORM:     next_state = ROUND;
            ROUND:    next_state = FINISHED;
            FINISHED: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            count     <= '0;
            exp_sum   <= '0;
            mant      <= '0;
            guard     <= 1'b0;
            y_reg     <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.A;
                        b_reg     <= bus.B;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                    end
                end
                CHECKS: begin
                    if (special) begin
                        y_reg <= special_y;
                    end else begin
                        mcand   <= {1'b1, a_reg[FRAC_W-1:0]};
                        mplier  <= {1'b1, b_reg[FRAC_W-1:0]};
                        exp_sum <= ({2'b00, a_reg[FRAC_W +: EXP_W]}
                                  + {2'b00, b_reg[FRAC_W +: EXP_W]})
                                  - 10'(FP_BIAS);
                        prod    <= '0;
                        count   <= '0;
                    end
                end
                MULT: begin
                    if (mplier[count]) begin
                        prod <= prod + ({24'd0, mcand} << count);
                    end
                    count <= count + 5'd1;
                end
                NORM: begin
                    // Product of two [1,2) mantissas lies in [1,4); bit 47 set means >= 2.
                    if (prod[47]) begin
                        mant    <= prod[46:24];
                        guard   <= prod[23];
                        exp_sum <= exp_sum + 10'sd1;
                    end else begin
                        mant    <= prod[45:23];
                        guard   <= prod[22];
                    end
                end
                ROUND: begin
                    if (exp_round >= 10'sd255) begin
                        y_reg <= {res_sign, FP_EXP_MAX, {FRAC_W{1'b0}}};
                    end else if (exp_round <= 10'sd0) begin
                        y_reg <= {res_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
                    end else begin
                        y_reg <= {res_sign, exp_round[EXP_W-1:0], rounded[FRAC_W-1:0]};
                    end
                end
                FINISHED: begin
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_reg;
    assign bus.busy  = busy_reg;
    assign bus.Y     = y_reg;

endmodule

// File: tb/tb_multiplier_fp.sv
// Directed self-checking bench for multiplier_fp: latency, specials, range limits,
// handshake corner cases and asynchronous reset mid-operation.
module tb_multiplier_fp;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multiplier_fp_if bus ();

    multiplier_fp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Called at posedge+1; returns at posedge+1 just after the edge that sampled start.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h1234_5678;
    endtask

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observes a normal-path operation: busy after edge 0, ready after edges 27 and 28.
    task automatic run_normal(input logic [31:0] a, input logic [31:0] b,
                              output logic [3:0] hs, output logic [31:0] y);
        logic b0, r27, r28, b28;
        start_op(a, b);
        b0 = bus.busy;
        skip(27);
        r27 = bus.ready;
        skip(1);
        r28 = bus.ready;
        b28 = bus.busy;
        hs  = {b0, r27, r28, b28};
        y   = bus.Y;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b1;
        #2;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.ready, bus.busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_flags: ready/busy=%b expected 00", {bus.ready, bus.busy});
        end
        total++;
        if (bus.Y !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_y: Y=%h expected 00000000", bus.Y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0]  hs;
        logic [31:0] y;
        run_normal(32'h4040_0000, 32'h4000_0000, hs, y);
        total++;
        if (hs !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL basic_latency: busy0/ready27/ready28/busy28=%b expected 1010", hs);
        end
        total++;
        if (y !== 32'h40C0_0000) begin
            bad++;
            $display("[TB] FAIL basic_y: Y=%h expected 40c00000", y);
        end
    endtask

    task automatic test_sign_round();
        logic [31:0] va[2]  = '{32'hBFC0_0000, 32'h3F80_0001};
        logic [31:0] vb[2]  = '{32'h3FC0_0000, 32'h3F80_0001};
        logic [31:0] exp[2] = '{32'hC010_0000, 32'h3F80_0002};
        logic [3:0]  hs;
        logic [31:0] y;
        for (int i = 0; i < 2; i++) begin
            run_normal(va[i], vb[i], hs, y);
            total++;
            if (hs !== 4'b1010) begin
                bad++;
                $display("[TB] FAIL sign_latency[%0d]: handshake=%b expected 1010", i, hs);
            end
            total++;
            if (y !== exp[i]) begin
                bad++;
                $display("[TB] FAIL sign_y[%0d]: Y=%h expected %h", i, y, exp[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[4]  = '{32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001};
        logic [31:0] vb[4]  = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
        logic [31:0] exp[4] = '{32'h7F80_0001, 32'h7F80_0001, 32'hFF80_0000, 32'h0000_0000};
        logic r1, r2;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            skip(1);
            r1 = bus.ready;
            skip(1);
            r2 = bus.ready;
            total++;
            if ({r1, r2} !== 2'b01) begin
                bad++;
                $display("[TB] FAIL special_latency[%0d]: ready1/ready2=%b expected 01", i, {r1, r2});
            end
            total++;
            if (bus.Y !== exp[i]) begin
                bad++;
                $display("[TB] FAIL special_y[%0d]: Y=%h expected %h", i, bus.Y, exp[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] va[3]  = '{32'h7F00_0000, 32'h0080_0000, 32'h8080_0000};
        logic [31:0] vb[3]  = '{32'h7F00_0000, 32'h0080_0000, 32'h0080_0000};
        logic [31:0] exp[3] = '{32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};
        logic [3:0]  hs;
        logic [31:0] y;
        for (int i = 0; i < 3; i++) begin
            run_normal(va[i], vb[i], hs, y);
            total++;
            if (hs !== 4'b1010 || y !== exp[i]) begin
                bad++;
                $display("[TB] FAIL range[%0d]: handshake=%b Y=%h expected 1010 %h", i, hs, y, exp[i]);
            end
        end
    endtask

    task automatic test_start_held();
        logic seen;
        seen      = 1'b0;
        bus.A     = 32'h4040_0000;
        bus.B     = 32'h4000_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i < 28; i++) begin
            skip(1);
            seen = seen | bus.ready;
        end
        skip(1);
        bus.start = 1'b0;
        total++;
        if ({seen, bus.ready} !== 2'b01 || bus.Y !== 32'h40C0_0000) begin
            bad++;
            $display("[TB] FAIL held_start: early=%b ready28=%b Y=%h expected 0 1 40c00000",
                     seen, bus.ready, bus.Y);
        end
        skip(5);
        total++;
        if ({bus.ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL held_single: ready/busy=%b expected 10", {bus.ready, bus.busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  hs;
        logic [31:0] y;
        run_normal(32'h4040_0000, 32'h4000_0000, hs, y);
        start_op(32'hBFC0_0000, 32'h3FC0_0000);
        total++;
        if ({bus.ready, bus.busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL b2b_accept: ready/busy=%b expected 01", {bus.ready, bus.busy});
        end
        skip(27);
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_ready_low: ready=%b expected 0", bus.ready);
        end
        skip(1);
        total++;
        if (bus.ready !== 1'b1 || bus.Y !== 32'hC010_0000) begin
            bad++;
            $display("[TB] FAIL b2b_y: ready=%b Y=%h expected 1 c0100000", bus.ready, bus.Y);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  hs;
        logic [31:0] y;
        start_op(32'h4040_0000, 32'h4000_0000);
        skip(10);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ready, bus.busy} !== 2'b00 || bus.Y !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: ready/busy=%b Y=%h expected 00 00000000",
                     {bus.ready, bus.busy}, bus.Y);
        end
        #3;
        rst_n = 1'b1;
        skip(1);
        skip(20);
        total++;
        if ({bus.ready, bus.busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_abandon: ready/busy=%b expected 00", {bus.ready, bus.busy});
        end
        run_normal(32'hBFC0_0000, 32'h3FC0_0000, hs, y);
        total++;
        if (hs !== 4'b1010 || y !== 32'hC010_0000) begin
            bad++;
            $display("[TB] FAIL reset_recover: handshake=%b Y=%h expected 1010 c0100000", hs, y);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_round();
        test_specials();
        test_range();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
